// File: rtl/spi_slave_rx_tx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_tx
//
// SPI mode-0 (CPOL=0, CPHA=0) target that runs entirely on the system clock.
// The master's SCLK, CS_N and MOSI are oversampled through synchronizers and
// edge-detected. Received bytes are delivered as single-cycle strobes. Reply
// bytes are accepted through a one-entry holding register.
//
// Optional feature macro: SPI_SLAVE_ECHO_EN
//   defined   : with nothing held, the byte shifted out is the most recent
//               received byte (8'h00 after reset).
//   undefined : with nothing held, the byte shifted out is DEFAULT_TX.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on sclk/cs_n/mosi (>= 2)
//   DEFAULT_TX   fallback reply byte when the echo feature is disabled
//
// Ports
//   i_clk       system clock (>= 10x SCLK)
//   i_rst       asynchronous active-high reset
//   i_sclk      SPI clock from the master (idles low)
//   i_cs_n      chip select, active low
//   i_mosi      serial data from the master
//   o_miso      serial data to the master, 0 while deselected
//   i_tx_data   reply byte
//   i_tx_valid  i_tx_data is offered
//   o_tx_ready  holding register is empty
//   o_rx_data   last complete received byte
//   o_rx_valid  one-cycle strobe, o_rx_data has been updated
//   o_active    a frame is in progress
// ---------------------------------------------------------------------------
module spi_slave_rx_tx #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DEFAULT_TX  = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_active
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains; bit 0 is the first stage.
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  state_t     r_state;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  logic       w_sclk_s;
  logic       w_cs_s;
  logic       w_mosi_s;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_load;
  logic       w_accept;
  logic [7:0] w_fallback;

  // -------------------------------------------------------------------------
  // Input synchronizers plus one delay flop per edge-detected signal.
  // cs_n resets high so that reset itself never looks like a selection.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   i_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
  assign w_cs_fall   = ~w_cs_s   &  r_cs_d;
  assign w_cs_rise   =  w_cs_s   & ~r_cs_d;

`ifdef SPI_SLAVE_ECHO_EN
  assign w_fallback = r_rx_data;
`else
  assign w_fallback = DEFAULT_TX;
`endif

  // A new reply byte is loaded at frame start and on the falling edge that
  // follows the 8th rising edge (bit_cnt has wrapped back to 0 by then).
  // In mode 0 the first edge of a frame is always a rising one, so a falling
  // edge with bit_cnt==0 can only be the end of a byte.
  assign w_load   = ((r_state == ST_IDLE) && w_cs_fall) ||
                    ((r_state == ST_ACTIVE) && !w_cs_rise && w_sclk_fall &&
                     (r_bit_cnt == 3'd0));
  assign w_accept = i_tx_valid && !r_hold_full;

  // -------------------------------------------------------------------------
  // Frame FSM with shift registers and holding register.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_tx_shift  <= 8'h00;
      r_rx_shift  <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // sclk activity while deselected is ignored
          if (w_cs_fall) begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            // Abort/end of frame: partial byte and outgoing byte are dropped
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'h00;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_rx_data  <= {r_rx_shift[6:0], w_mosi_s};
                r_rx_valid <= 1'b1;
              end
            end
            if (w_sclk_fall && (r_bit_cnt != 3'd0)) begin
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // The load always sees the holding contents from before this cycle,
      // so a byte accepted in the same cycle waits for the next load.
      if (w_load) begin
        if (r_hold_full) begin
          r_tx_shift  <= r_hold;
          r_hold_full <= 1'b0;
        end else begin
          r_tx_shift  <= w_fallback;
        end
      end

      // w_accept implies the register was empty, so it never collides with
      // the emptying branch above.
      if (w_accept) begin
        r_hold      <= i_tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign o_miso     = (r_state == ST_ACTIVE) & r_tx_shift[7];
  assign o_tx_ready = ~r_hold_full;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_active   = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// ---------------------------------------------------------------------------
// Directed testbench for spi_slave_rx_tx. The bench acts as a mode-0 master
// with SCLK half-period of 5 system clocks and logs every rx strobe.
// ---------------------------------------------------------------------------
module tb_spi_slave_rx_tx;

  localparam int         SYNC = 2;
  localparam logic [7:0] DTX  = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       active;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rx_log[$];

  spi_slave_rx_tx #(
    .SYNC_STAGES (SYNC),
    .DEFAULT_TX  (DTX)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sclk     (sclk),
    .i_cs_n     (cs_n),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_tx_ready (tx_ready),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .o_active   (active)
  );

  always #5 clk = ~clk;

  // Every high cycle of rx_valid is one logged byte, so a stretched strobe
  // shows up as an extra entry.
  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  // Master shifts nbits of mo out (MSB first) and samples miso just before
  // each rising edge.
  task automatic xfer(input logic [7:0] mo, output logic [7:0] mi, input int nbits = 8);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(5);
      mi[7-i] = miso;
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
  endtask

  task automatic offer(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] m1, m2, exp_first, exp_echo;
    int base;

    // ---------------- reset state ----------------
    wait_clk(3);
    check("rst_miso",     32'(miso),     32'h0);
    check("rst_tx_ready", 32'(tx_ready), 32'h1);
    check("rst_rx_data",  32'(rx_data),  32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_active",   32'(active),   32'h0);
    rst = 1'b0;
    wait_clk(4);
    check("idle_active", 32'(active), 32'h0);

    // ---------------- basic receive ----------------
    base = rx_log.size();
    cs_low();
    check("basic_active", 32'(active), 32'h1);
    xfer(8'hA5, m1);
    cs_high();
    check("basic_rx_cnt",  32'(rx_log.size()), 32'(base + 1));
    check("basic_rx_data", 32'(rx_data), 32'hA5);
    check("basic_miso",    32'(m1), 32'(DTX));
    check("basic_inactive", 32'(active), 32'h0);
    check("basic_miso_idle", 32'(miso), 32'h0);

    // ---------------- preloaded reply ----------------
    offer(8'h3C);
    check("pre_ready_drop", 32'(tx_ready), 32'h0);
    base = rx_log.size();
    cs_low();
    check("pre_ready_rise", 32'(tx_ready), 32'h1);
    xfer(8'h00, m1);
    cs_high();
    check("pre_miso",    32'(m1), 32'h3C);
    check("pre_rx_cnt",  32'(rx_log.size()), 32'(base + 1));
    check("pre_rx_data", 32'(rx_data), 32'h00);

    // ---------------- two-byte frame ----------------
    offer(8'hC3);
    check("two_ready_drop", 32'(tx_ready), 32'h0);
    base = rx_log.size();
    cs_low();
    check("two_ready_rise", 32'(tx_ready), 32'h1);
    offer(8'h5A);
    check("two_ready_full", 32'(tx_ready), 32'h0);
    xfer(8'h12, m1);
    xfer(8'h34, m2);
    cs_high();
    check("two_miso0",  32'(m1), 32'hC3);
    check("two_miso1",  32'(m2), 32'h5A);
    check("two_rx_cnt", 32'(rx_log.size()), 32'(base + 2));
    if (rx_log.size() >= base + 2) begin
      check("two_rx0", 32'(rx_log[base]),     32'h12);
      check("two_rx1", 32'(rx_log[base + 1]), 32'h34);
    end
    check("two_ready_end", 32'(tx_ready), 32'h1);

    // ---------------- abort after 5 sclk edges ----------------
    base = rx_log.size();
    cs_low();
    sclk = 1'b1; wait_clk(5);
    sclk = 1'b0; wait_clk(5);
    sclk = 1'b1; wait_clk(5);
    sclk = 1'b0; wait_clk(5);
    sclk = 1'b1; wait_clk(5);
    cs_high();
    check("abort_rx_cnt",  32'(rx_log.size()), 32'(base));
    check("abort_bit_cnt", 32'(dut.r_bit_cnt), 32'h0);
    check("abort_active",  32'(active), 32'h0);
    sclk = 1'b0;
    wait_clk(8);
    cs_low();
    xfer(8'hF0, m1);
    cs_high();
    check("abort_next_cnt",  32'(rx_log.size()), 32'(base + 1));
    check("abort_next_data", 32'(rx_data), 32'hF0);

    // ---------------- echo / fallback on second byte ----------------
`ifdef SPI_SLAVE_ECHO_EN
    exp_first = 8'hF0;
    exp_echo  = 8'h81;
`else
    exp_first = DTX;
    exp_echo  = DTX;
`endif
    base = rx_log.size();
    cs_low();
    xfer(8'h81, m1);
    xfer(8'h00, m2);
    cs_high();
    check("echo_miso0",  32'(m1), 32'(exp_first));
    check("echo_miso1",  32'(m2), 32'(exp_echo));
    check("echo_rx_cnt", 32'(rx_log.size()), 32'(base + 2));
    check("echo_rx_data", 32'(rx_data), 32'h00);

    // ---------------- reset mid-frame ----------------
    cs_low();
    xfer(8'hFF, m1, 3);
    wait_clk(2);
    rst = 1'b1;
    #1;
    check("mrst_miso",     32'(miso),     32'h0);
    check("mrst_tx_ready", 32'(tx_ready), 32'h1);
    check("mrst_rx_data",  32'(rx_data),  32'h00);
    check("mrst_rx_valid", 32'(rx_valid), 32'h0);
    check("mrst_active",   32'(active),   32'h0);
    check("mrst_bit_cnt",  32'(dut.r_bit_cnt), 32'h0);
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(8);
    check("mrst_idle", 32'(active), 32'h0);
    base = rx_log.size();
    cs_low();
    xfer(8'h7E, m1);
    cs_high();
    check("mrst_rx_cnt",  32'(rx_log.size()), 32'(base + 1));
    check("mrst_rx_data", 32'(rx_data), 32'h7E);
    check("mrst_miso",    32'(m1), 32'(DTX));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_tx.md
# spi_slave_rx_tx

SPI mode-0 responder (target) clocked entirely by the system clock; it oversamples an external master's SCLK/CS_N/MOSI and drives MISO. It forms the far end of the bridge's SPI link and is the loopback partner for the bridge's SPI master in system benches. It delivers received bytes as single-cycle strobes and accepts reply bytes through a one-entry holding register.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth on sclk, cs_n and mosi. Legal values are ≥ 2.
- DEFAULT_TX, 8'h00: byte shifted out when no reply byte is pending.

Ports:
- clk  input  1  system clock. Must run at ≥ 10× the SCLK frequency.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from the master. CPOL=0.
- cs_n  input  1  chip select, active low.
- mosi  input  1  serial data from the master.
- miso  output  1  serial data to the master. Driven 0 while deselected; never tristated.
- tx_data  input  8  reply byte.
- tx_valid  input  1  tx_data is offered.
- tx_ready  output  1  holding register is empty.
- rx_data  output  8  last complete received byte.
- rx_valid  output  1  one-cycle strobe: rx_data has been updated.
- active  output  1  a frame is in progress (synchronized cs_n is low).

## Operation
- **Synchronizers:** sclk, cs_n and mosi pass through SYNC_STAGES flops each. The flops reset to 0, 1 and 0 respectively.
  - Edge detection compares the last synchronizer stage with one extra delay flop.
- **States:** IDLE and ACTIVE.
  - IDLE → ACTIVE on a detected cs_n falling edge.
  - ACTIVE → IDLE on a detected cs_n rising edge.
- **Byte load:** at IDLE→ACTIVE and at every 8th sclk falling edge, the tx shift register loads the next byte.
  - If the holding register is full, it loads the holding byte and the holding register is emptied.
  - If the holding register is empty, it loads the fallback byte (DEFAULT_TX, or see Configuration).
- **Bit transfer:** MSB first.
  - miso = tx_shift[7] while ACTIVE.
  - On each sclk falling edge, tx_shift shifts left.
  - On each sclk rising edge, mosi is shifted into rx_shift and bit_cnt increments. bit_cnt is 3 bits and wraps 7→0.
  - When bit_cnt wraps, rx_data ← the completed byte and rx_valid pulses.
  - There is no backpressure on the receive path: the consumer must take rx_data before the next byte completes.
- **Holding register:**
  - tx_ready = !hold_full.
  - A transfer occurs when tx_valid && tx_ready.
  - If an accept and a load happen in the same cycle, the load uses the prior holding contents. The holding register is empty, so the shift register gets the fallback byte, and the accepted byte goes into the holding register. There is no bypass path.
- **cs_n rises mid-byte:**
  - The partial rx byte is discarded; no rx_valid.
  - bit_cnt is reset to 0.
  - The byte being shifted out is lost.
  - The holding register is retained.
- **sclk edges in IDLE** are ignored.
- **rst mid-frame** returns all state to its reset values immediately. The block re-enters ACTIVE only on a fresh detected cs_n falling edge.

## Timing
- **Reset values:**
  - miso = 0, tx_ready = 1, rx_data = 8'h00, rx_valid = 0, active = 0.
  - bit_cnt = 0, hold register empty.
- **Edge detection latency:** a pin edge becomes a detected edge SYNC_STAGES+1 clk cycles later. Registered results appear in the following cycle.
- **rx_valid** is high for exactly 1 cycle, SYNC_STAGES+2 cycles after the 8th sclk rising pin edge.
- **miso updates** SYNC_STAGES+2 cycles after an sclk falling pin edge or the cs_n falling pin edge.
- **Master constraints:**
  - The first sclk rising edge occurs ≥ SYNC_STAGES+3 clk after cs_n falls.
  - The sclk half-period is ≥ 5 clk.
  - cs_n rises ≥ SYNC_STAGES+3 clk after the last sclk falling edge.
- **active** rises or falls SYNC_STAGES+2 cycles after the cs_n pin edge.
- **tx_ready** drops in the cycle after an accept. It rises in the cycle after a load empties the holding register.

## Configuration
- **SPI_SLAVE_ECHO_EN defined:** the fallback byte is the most recent rx_data, i.e. the last completed received byte. After reset that byte is 8'h00.
- **SPI_SLAVE_ECHO_EN undefined:** the fallback byte is DEFAULT_TX.
- Either way, a pending holding byte always takes priority over the fallback byte.

## Test plan
- **Basic receive:** reset, then with clk at 10× sclk the master sends 8'hA5 → exactly one rx_valid pulse with rx_data = 8'hA5, and miso returns DEFAULT_TX 8'h00.
- **Preloaded reply:** tx_data = 8'h3C accepted while idle (tx_ready drops), master sends 8'h00 → master samples 8'h3C and tx_ready rises after the frame's first load.
- **Two-byte frame:** 8'hC3 is held, and 8'h5A is written after tx_ready rises; master sends 8'h12, 8'h34 → rx strobes 8'h12 then 8'h34 and miso carries 8'hC3 then 8'h5A.
- **Abort:** cs_n rises after 5 sclk edges → no rx_valid and bit_cnt = 0. A following full frame of 8'hF0 → rx_data = 8'hF0.
- **Echo:** with SPI_SLAVE_ECHO_EN defined and nothing held, frame 8'h81 then 8'h00 → the second byte's miso reads 8'h81.
- **Reset mid-frame:** rst pulsed after bit 3 → all outputs at reset values, then a clean next frame of 8'h7E → rx_data = 8'h7E.
